ones_comp_serial_ctrl: RTL and testbench



---
 rtl/ones_comp_pkg.sv | 15 +
 rtl/full_adder.sv | 19 +
 rtl/ones_comp_serial_ctrl.sv | 159 +++++++++++++++
 tb/tb_ones_comp_serial_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ones_comp_pkg.sv
// Shared definitions for the bit-serial ones' complement add/subtract sequencer.
//   state_t    : sequencer states (IDLE, ADD, WRAP, DONE)
//   DEF_WIDTH  : default operand/result width
package ones_comp_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        WRAP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : ones_comp_pkg

// File: rtl/full_adder.sv
// Single-bit full adder, time-shared by the serial sequencer.
//   A, B, C : addend bits and carry in
//   Y       : sum bit
//   cout    : carry out
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Y,
    output logic cout
);

    // Sum and carry of three input bits
    always_comb begin
        Y    = A ^ B ^ C;
        cout = (A & B) | (C & (A ^ B));
    end

endmodule : full_adder

// File: rtl/ones_comp_serial_ctrl.sv
// Bit-serial ones' complement add/subtract sequencer. One full_adder is reused
// LSB first for an add pass; when that pass carries out of the MSB, a second
// pass of WIDTH cycles adds the end-around carry back in.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request pulse, accepted only when not busy
//   op_sub     : 0 = a+b, 1 = a-b (b inverted at capture)
//   a, b       : operands, sampled with start
//   busy       : high while in ADD or WRAP
//   done       : one-cycle pulse, result/overflow/neg_zero valid
//   result     : ones' complement result, updated only in the DONE cycle
//   overflow   : signed ones' complement overflow of the last operation
//   neg_zero   : result is all ones
module ones_comp_serial_ctrl
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             neg_zero
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             state_r, state_n;
    logic [WIDTH-1:0]   acc_r, acc_n;
    logic [WIDTH-1:0]   opnd_r, opnd_n;
    logic               carry_r, carry_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic               sign_a_r, sign_a_n;
    logic               sign_o_r, sign_o_n;
    logic               busy_r, done_r, overflow_r, neg_zero_r;
    logic [WIDTH-1:0]   result_r;
    logic               fa_a_s, fa_b_s, fa_y_s, fa_co_s;
    logic               last_bit_s;

    assign last_bit_s = (idx_r == LAST_IDX);

    full_adder u_fa (
        .A    (fa_a_s),
        .B    (fa_b_s),
        .C    (carry_r),
        .Y    (fa_y_s),
        .cout (fa_co_s)
    );

    // Next-state, adder input muxing and datapath update
    always_comb begin
        state_n  = state_r;
        acc_n    = acc_r;
        opnd_n   = opnd_r;
        carry_n  = carry_r;
        idx_n    = idx_r;
        sign_a_n = sign_a_r;
        sign_o_n = sign_o_r;
        fa_a_s   = acc_r[idx_r];
        fa_b_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    acc_n    = a;
                    opnd_n   = op_sub ? ~b : b;
                    carry_n  = 1'b0;
                    idx_n    = {IDX_W{1'b0}};
                    sign_a_n = a[WIDTH-1];
                    sign_o_n = op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    state_n  = ADD;
                end else begin
                    state_n  = IDLE;
                end
            end
            ADD: begin
                fa_b_s       = opnd_r[idx_r];
                acc_n[idx_r] = fa_y_s;
                carry_n      = fa_co_s;
                if (last_bit_s) begin
                    idx_n = {IDX_W{1'b0}};
                    if (fa_co_s) begin
                        // carry out of the MSB re-enters at the LSB
                        state_n = WRAP;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    idx_n = idx_r + IDX_W'(1);
                end
            end
            WRAP: begin
                acc_n[idx_r] = fa_y_s;
                carry_n      = fa_co_s;
                if (last_bit_s) begin
                    // a carry out here cannot happen; it is dropped
                    idx_n   = {IDX_W{1'b0}};
                    carry_n = 1'b0;
                    state_n = DONE;
                end else begin
                    idx_n = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            acc_r      <= {WIDTH{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            sign_a_r   <= 1'b0;
            sign_o_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
            neg_zero_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            acc_r    <= acc_n;
            opnd_r   <= opnd_n;
            carry_r  <= carry_n;
            idx_r    <= idx_n;
            sign_a_r <= sign_a_n;
            sign_o_r <= sign_o_n;
            busy_r   <= (state_n == ADD) || (state_n == WRAP);
            done_r   <= (state_n == DONE);
            // outputs are loaded from the final accumulator on entry to DONE
            if (state_n == DONE) begin
                result_r   <= acc_n;
                overflow_r <= (sign_a_r == sign_o_r) && (acc_n[WIDTH-1] != sign_a_r);
                neg_zero_r <= &acc_n;
            end else begin
                result_r   <= result_r;
                overflow_r <= overflow_r;
                neg_zero_r <= neg_zero_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign overflow = overflow_r;
    assign neg_zero = neg_zero_r;

endmodule : ones_comp_serial_ctrl

// File: tb/tb_ones_comp_serial_ctrl.sv
// Self-checking bench for ones_comp_serial_ctrl (WIDTH=4): directed test-plan
// scenarios, randomized operations against an arithmetic reference model,
// handshake, back-to-back issue and mid-operation reset.
module tb_ones_comp_serial_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         neg_zero;

    int errors = 0;
    int checks = 0;

    ones_comp_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .neg_zero (neg_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ones' complement values and end-around-carry arithmetic
    function automatic int oc_val(input logic [W-1:0] x);
        logic [W-1:0] t;
        t = ~x;
        return x[W-1] ? -int'(t) : int'(x);
    endfunction

    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic isub, output logic [W-1:0] r,
                                  output logic ov, output logic nz, output int lat);
        logic [W-1:0] opnd;
        int raw, sum, maxv;
        opnd = isub ? ~ib : ib;
        raw  = int'(ia) + int'(opnd);
        if (raw >= (1 << W)) begin
            raw = raw - (1 << W) + 1;
            lat = 2 * W + 1;
        end else begin
            lat = W + 1;
        end
        r    = raw[W-1:0];
        maxv = (1 << (W - 1)) - 1;
        sum  = oc_val(ia) + (isub ? -oc_val(ib) : oc_val(ib));
        ov   = (sum > maxv) || (sum < -maxv);
        nz   = (r == {W{1'b1}});
    endfunction

    // Issue one operation and wait (bounded) for done; returns in the done cycle
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         output int lat, output logic [W-1:0] r, output logic ov,
                         output logic nz, output logic busy_ok);
        a = ia; b = ib; op_sub = isub; start = 1'b1;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
        lat = -1; r = 'x; ov = 1'bx; nz = 1'bx; busy_ok = 1'b1;
        for (int c = 1; c <= 3 * W + 4; c++) begin
            if (done) begin
                lat = c; r = result; ov = overflow; nz = neg_zero;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 4'b0000) begin errors++; $display("FAIL reset_result got=%b exp=0000", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (neg_zero !== 1'b0) begin errors++; $display("FAIL reset_neg_zero got=%b exp=0", neg_zero); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{4'b0101, 4'b0101, 4'b0011, 4'b0110};
        logic [W-1:0] tb [4] = '{4'b0010, 4'b0010, 4'b0011, 4'b0011};
        logic         ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] er [4] = '{4'b0111, 4'b0011, 4'b1111, 4'b1001};
        logic         eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic         en [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int           el [4] = '{5, 9, 5, 5};
        int lat; logic [W-1:0] r; logic ov, nz, bok;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], ts[i], lat, r, ov, nz, bok);
            checks++; if (lat != el[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
            checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_result got=%b exp=%b", i, r, er[i]); end
            checks++; if (ov !== eo[i]) begin errors++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, ov, eo[i]); end
            checks++; if (nz !== en[i]) begin errors++; $display("FAIL dir%0d_neg_zero got=%b exp=%b", i, nz, en[i]); end
            checks++; if (bok !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b exp=1", i, bok); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ia, ib, r, er;
        logic isub, ov, nz, eo, en, bok;
        int lat, el;
        for (int i = 0; i < 40; i++) begin
            ia = W'($urandom_range(0, (1 << W) - 1));
            ib = W'($urandom_range(0, (1 << W) - 1));
            isub = 1'($urandom);
            model(ia, ib, isub, er, eo, en, el);
            do_op(ia, ib, isub, lat, r, ov, nz, bok);
            checks++; if (lat != el) begin errors++; $display("FAIL rnd_latency a=%b b=%b sub=%b got=%0d exp=%0d", ia, ib, isub, lat, el); end
            checks++; if (r !== er) begin errors++; $display("FAIL rnd_result a=%b b=%b sub=%b got=%b exp=%b", ia, ib, isub, r, er); end
            checks++; if (ov !== eo) begin errors++; $display("FAIL rnd_overflow a=%b b=%b sub=%b got=%b exp=%b", ia, ib, isub, ov, eo); end
            checks++; if (nz !== en) begin errors++; $display("FAIL rnd_neg_zero a=%b b=%b sub=%b got=%b exp=%b", ia, ib, isub, nz, en); end
            checks++; if (bok !== 1'b1) begin errors++; $display("FAIL rnd_busy a=%b b=%b sub=%b got=%b exp=1", ia, ib, isub, bok); end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_handshake_ignore();
        int ndone = 0; int first = -1; logic [W-1:0] r = '0;
        a = 4'b0101; b = 4'b0010; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) begin start = 1'b1; a = 4'b1111; b = 4'b1111; op_sub = 1'b1; end
            if (c == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; r = result; end
            end
            tick();
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL hs_done_count got=%0d exp=1", ndone); end
        checks++; if (first != 5) begin errors++; $display("FAIL hs_done_cycle got=%0d exp=5", first); end
        checks++; if (r !== 4'b0111) begin errors++; $display("FAIL hs_result got=%b exp=0111", r); end
    endtask

    task automatic test_back_to_back();
        int lat; int first = -1; logic [W-1:0] r, r2 = '0; logic ov, nz, bok; logic held = 1'b1;
        do_op(4'b0101, 4'b0010, 1'b0, lat, r, ov, nz, bok);
        checks++; if (lat != 5) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=5", lat); end
        a = 4'b0001; b = 4'b0001; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        for (int c = 1; c <= 12; c++) begin
            if (done && first < 0) begin first = c; r2 = result; end
            if (first < 0 && result !== 4'b0111) held = 1'b0;
            tick();
        end
        checks++; if (first != 5) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=5", first); end
        checks++; if (r2 !== 4'b0010) begin errors++; $display("FAIL b2b_result got=%b exp=0010", r2); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_result_held got=%b exp=1", held); end
    endtask

    task automatic test_reset_midop();
        int lat, ndone = 0; logic [W-1:0] r; logic ov, nz, bok;
        // leave a nonzero result with overflow set before the aborted op
        do_op(4'b0110, 4'b0011, 1'b0, lat, r, ov, nz, bok);
        tick();
        a = 4'b0101; b = 4'b0010; op_sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (result !== 4'b0000) begin errors++; $display("FAIL rst_mid_result got=%b exp=0000", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", ndone); end
        do_op(4'b0101, 4'b0010, 1'b0, lat, r, ov, nz, bok);
        checks++; if (lat != 5) begin errors++; $display("FAIL rst_mid_fresh_latency got=%0d exp=5", lat); end
        checks++; if (r !== 4'b0111) begin errors++; $display("FAIL rst_mid_fresh_result got=%b exp=0111", r); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rst_mid_fresh_overflow got=%b exp=0", ov); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_handshake_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ones_comp_serial_ctrl
